gemm_tile_gen: RTL and testbench
================================

Name: gemm_tile_gen

Overview:
Command-side tile generator that feeds the systolic-array mode decoder. It accepts one GEMM command giving total reduction depth K and total output width N, then emits a stream of tile descriptors. Each descriptor carries ksize/nsize (5-bit, same encoding the decoder consumes), tile offsets and accumulation flags. Sits between the command front-end and the decoder/dispatch path; tiles are issued N-outer, K-inner so partial sums accumulate contiguously.

Parameters:
DIM_W, 16, width of total_k/total_n and offset outputs
TILE_K_MAX, 16, max ksize per tile (1..31)
TILE_N_MAX, 16, max nsize per tile (1..31)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept command
total_k  input  DIM_W  total reduction depth
total_n  input  DIM_W  total output columns
tile_valid  output  1  descriptor valid
tile_ready  input  1  downstream accepts descriptor
ksize  output  5  rows of this tile (1..TILE_K_MAX)
nsize  output  5  cols of this tile (1..TILE_N_MAX)
k_off  output  DIM_W  K offset of tile
n_off  output  DIM_W  N offset of tile
first_k  output  1  first K-tile of current N-strip (clear accumulators)
last_k  output  1  last K-tile of current N-strip (drain results)
last_tile  output  1  final descriptor of command
cmd_err  output  1  one-cycle pulse: zero-size command dropped
busy  output  1  command in progress

Behaviour:
- Reset (rst low, async): state IDLE; cmd_ready=1; tile_valid=0; busy=0; cmd_err=0; ksize/nsize/k_off/n_off=0; all flags 0.
- States: IDLE, EMIT.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch total_k/total_n.
  - If total_k==0 or total_n==0: cmd_err=1 next cycle, stay IDLE, no tiles.
  - Otherwise: go to EMIT with k_off=0, n_off=0 and the first descriptor registered. tile_valid rises the cycle after acceptance (1-cycle latency).
- EMIT: cmd_ready=0; busy=1. All descriptor outputs are registered and held stable while tile_valid & !tile_ready (AXI-style; valid never drops without a handshake).
- Tile sizes: ksize=min(TILE_K_MAX, total_k-k_off); nsize=min(TILE_N_MAX, total_n-n_off). The subtraction is DIM_W wide; the result is truncated to 5 bits only after the min.
- Flags: first_k=(k_off==0); last_k=(k_off+ksize==total_k); last_tile=last_k && (n_off+nsize==total_n).
- On handshake (tile_valid&tile_ready):
  - if !last_k: k_off+=TILE_K_MAX.
  - else if !last_tile: k_off=0, n_off+=TILE_N_MAX.
  - else: tile_valid=0, go to IDLE; cmd_ready=1 the following cycle, so there is no back-to-back accept in the same cycle as the last handshake.
- Offset arithmetic is computed at DIM_W+1 bits to avoid wrap when total is near 2^DIM_W-1. No descriptor ever exceeds the totals.
- tile_ready while tile_valid=0 is ignored. cmd_valid during EMIT is ignored (not latched).
- Reset mid-command: drops everything immediately, returns to IDLE; no partial descriptor survives.
- Tile count per command = ceil(K/TILE_K_MAX)*ceil(N/TILE_N_MAX); full throughput of one tile per cycle under constant tile_ready.

Decomposition:
- Config package gains TILE_K_MAX/TILE_N_MAX defaults (tied to SMALL_SYS_ROWS/SMALL_SYS_COLS scaling) and a packed tile_desc_t struct {ksize, nsize, k_off, n_off, first_k, last_k, last_tile}, so the decoder path consumes one struct.
- One natural sub-module: tile_dim_cnt, a single-axis offset counter with remaining/min/last logic, instantiated once for K and once for N.

Test Plan:
- total_k=40, total_n=20, max 16/16, tile_ready=1 → 6 tiles: ksize 16,16,8 / nsize 16 then 16,16,8 / nsize 4; first_k on tiles 1,4; last_k on 3,6; last_tile on 6 only.
- total_k=16, total_n=16 → single tile ksize=16, nsize=16 with first_k=last_k=last_tile=1; cmd_ready returns 1 two cycles after acceptance.
- total_k=0, total_n=5 → cmd_err pulses once, no tile_valid, cmd_ready stays 1.
- Random tile_ready stalls on a 48x48 command → descriptors stable during stall, exactly 9 tiles, ordering unchanged versus no-stall run.
- Assert rst mid-command (after tile 2 of 6) → outputs return to reset values asynchronously; next command starts with k_off=n_off=0.
- total_k=65535, total_n=1, DIM_W=16 → last tile ksize=15, k_off=65520; no wrap, last_tile=1.

Source files
------------

// File: rtl/gemm_tile_gen_pkg.sv
// gemm_tile_gen_pkg: tile-size defaults, FSM states and the tile descriptor consumed by the decoder path.
package gemm_tile_gen_pkg;
    localparam int SMALL_SYS_ROWS = 16;
    localparam int SMALL_SYS_COLS = 16;
    localparam int TILE_K_MAX_DEF = SMALL_SYS_ROWS;
    localparam int TILE_N_MAX_DEF = SMALL_SYS_COLS;
    localparam int DESC_OFF_W = 16;
    typedef enum logic {IDLE, EMIT} state_t;
    typedef struct packed {
        logic [4:0]            ksize;
        logic [4:0]            nsize;
        logic [DESC_OFF_W-1:0] k_off;
        logic [DESC_OFF_W-1:0] n_off;
        logic                  first_k;
        logic                  last_k;
        logic                  last_tile;
    } tile_desc_t;
endpackage

// File: rtl/gemm_tile_gen_tile_dim_cnt.sv
// tile_dim_cnt: single-axis tile offset counter with clipped tile size and last-tile detect.
module tile_dim_cnt #(
    parameter int DIM_W    = 16,
    parameter int TILE_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             clr,
    input  logic [DIM_W-1:0] total_in,
    output logic [DIM_W-1:0] off,
    output logic [4:0]       size,
    output logic             last
);
    logic [DIM_W-1:0] total_q;
    logic [DIM_W:0]   rem;
    logic [DIM_W:0]   sz;
    logic [DIM_W:0]   nxt;
    // one extra bit keeps off+size exact when total sits near 2^DIM_W-1
    always_comb begin
        rem  = {1'b0, total_q} - {1'b0, off};
        sz   = rem < (DIM_W+1)'(TILE_MAX) ? rem : (DIM_W+1)'(TILE_MAX);
        nxt  = {1'b0, off} + sz;
        size = sz[4:0];
        last = nxt == {1'b0, total_q};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q <= '0;
            off     <= '0;
        end else if (load) begin
            total_q <= total_in;
            off     <= '0;
        end else if (clr) begin
            off <= '0;
        end else if (step) begin
            off <= off + DIM_W'(TILE_MAX);
        end
    end
endmodule

// File: rtl/gemm_tile_gen.sv
// gemm_tile_gen: splits one GEMM command into N-outer, K-inner tile descriptors with accumulation flags.
module gemm_tile_gen
    import gemm_tile_gen_pkg::*;
#(
    parameter int DIM_W      = 16,
    parameter int TILE_K_MAX = TILE_K_MAX_DEF,
    parameter int TILE_N_MAX = TILE_N_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DIM_W-1:0] total_k,
    input  logic [DIM_W-1:0] total_n,
    output logic             tile_valid,
    input  logic             tile_ready,
    output logic [4:0]       ksize,
    output logic [4:0]       nsize,
    output logic [DIM_W-1:0] k_off,
    output logic [DIM_W-1:0] n_off,
    output logic             first_k,
    output logic             last_k,
    output logic             last_tile,
    output logic             cmd_err,
    output logic             busy
);
    state_t           state_q, state_d;
    tile_desc_t       desc;
    logic [DIM_W-1:0] k_cnt_off, n_cnt_off;
    logic [4:0]       k_sz, n_sz;
    logic             k_last, n_last, accept, zero, hs, err_q;
    assign accept = cmd_valid & cmd_ready;
    assign zero   = total_k == '0 || total_n == '0;
    assign hs     = tile_valid & tile_ready;
    tile_dim_cnt #(.DIM_W(DIM_W), .TILE_MAX(TILE_K_MAX)) u_k_cnt (
        .clk(clk), .rst(rst), .load(accept), .step(hs & ~k_last), .clr(hs & k_last & ~n_last),
        .total_in(total_k), .off(k_cnt_off), .size(k_sz), .last(k_last)
    );
    tile_dim_cnt #(.DIM_W(DIM_W), .TILE_MAX(TILE_N_MAX)) u_n_cnt (
        .clk(clk), .rst(rst), .load(accept), .step(hs & k_last & ~n_last), .clr(1'b0),
        .total_in(total_n), .off(n_cnt_off), .size(n_sz), .last(n_last)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= accept & zero;
        end
    end
    always_comb begin
        state_d = state_q == IDLE ? (accept && !zero ? EMIT : IDLE)
                                  : (hs && k_last && n_last ? IDLE : EMIT);
    end
    // descriptor fields are forced to zero whenever no tile is on offer
    always_comb begin
        cmd_ready  = state_q == IDLE;
        busy       = state_q == EMIT;
        tile_valid = state_q == EMIT;
        cmd_err    = err_q;
        desc       = tile_valid ? '{ksize: k_sz, nsize: n_sz,
                                     k_off: DESC_OFF_W'(k_cnt_off), n_off: DESC_OFF_W'(n_cnt_off),
                                     first_k: k_cnt_off == '0, last_k: k_last,
                                     last_tile: k_last & n_last} : '0;
        ksize      = desc.ksize;
        nsize      = desc.nsize;
        k_off      = DIM_W'(desc.k_off);
        n_off      = DIM_W'(desc.n_off);
        first_k    = desc.first_k;
        last_k     = desc.last_k;
        last_tile  = desc.last_tile;
    end
endmodule

// File: tb/tb_gemm_tile_gen.sv
// tb_gemm_tile_gen: randomized-stall checks of gemm_tile_gen against a loop-based tiling model.
module tb_gemm_tile_gen;
    localparam int TK = 16;
    localparam int TN = 16;
    logic        clk = 0, rst = 0, cmd_valid = 0, tile_ready = 0;
    logic [15:0] total_k = 0, total_n = 0;
    logic        cmd_ready, tile_valid, first_k, last_k, last_tile, cmd_err, busy;
    logic [4:0]  ksize, nsize;
    logic [15:0] k_off, n_off;
    int          n_chk = 0, n_err = 0;
    typedef struct {int ks; int ns; int ko; int no; bit fk; bit lk; bit lt;} exp_t;
    exp_t q[$];

    gemm_tile_gen dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .total_k(total_k), .total_n(total_n), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .ksize(ksize), .nsize(nsize), .k_off(k_off), .n_off(n_off),
        .first_k(first_k), .last_k(last_k), .last_tile(last_tile),
        .cmd_err(cmd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // expected tile list straight from the tiling rules: N-outer, K-inner
    task automatic build(input int k, input int n);
        exp_t e;
        q.delete();
        for (int no = 0; no < n; no += TN)
            for (int ko = 0; ko < k; ko += TK) begin
                e.ks = (k - ko < TK) ? k - ko : TK;
                e.ns = (n - no < TN) ? n - no : TN;
                e.ko = ko;
                e.no = no;
                e.fk = ko == 0;
                e.lk = ko + e.ks == k;
                e.lt = e.lk && (no + e.ns == n);
                q.push_back(e);
            end
    endtask

    task automatic run_cmd(input int k, input int n, input int stall, input int abort_after);
        int idx = 0, guard = 0;
        build(k, n);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; total_k = 16'(k); total_n = 16'(n); tile_ready = 0;
        @(negedge clk);
        cmd_valid = 0;
        chk("valid_latency", tile_valid, 1);
        while (idx < q.size()) begin
            if (idx == abort_after) return;
            if (guard++ > 20000) begin chk("timeout", 0, 1); break; end
            if (!tile_valid) begin chk("valid_drop", 0, 1); break; end
            chk("ksize", ksize, q[idx].ks);
            chk("nsize", nsize, q[idx].ns);
            chk("k_off", k_off, q[idx].ko);
            chk("n_off", n_off, q[idx].no);
            chk("flags", {first_k, last_k, last_tile}, {q[idx].fk, q[idx].lk, q[idx].lt});
            chk("busy_ready", {busy, cmd_ready}, 2'b10);
            tile_ready = $urandom_range(99) >= stall;
            cmd_valid = 1'($urandom_range(1));
            total_k = 16'($urandom);
            total_n = 16'($urandom);
            if (tile_ready) idx++;
            @(negedge clk);
        end
        cmd_valid = 0; tile_ready = 0;
        chk("tile_count", idx, q.size());
        chk("done_valid", tile_valid, 0);
        chk("done_ready", cmd_ready, 1);
        chk("done_busy", busy, 0);
        chk("done_ksize", ksize, 0);
    endtask

    task automatic zero_cmd(input int k, input int n);
        cmd_valid = 1; total_k = 16'(k); total_n = 16'(n);
        @(negedge clk);
        cmd_valid = 0;
        chk("err_pulse", cmd_err, 1);
        chk("err_no_valid", tile_valid, 0);
        chk("err_ready", cmd_ready, 1);
        @(negedge clk);
        chk("err_clear", cmd_err, 0);
        chk("err_still_idle", {tile_valid, busy, cmd_ready}, 3'b001);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outs", {cmd_ready, tile_valid, busy, cmd_err, first_k, last_k, last_tile}, 7'b1000000);
        chk("rst_sizes", {ksize, nsize}, 0);
        chk("rst_offs", {k_off, n_off}, 0);
        rst = 1;
        @(negedge clk);
        run_cmd(40, 20, 0, -1);
        run_cmd(16, 16, 0, -1);
        zero_cmd(0, 5);
        zero_cmd(7, 0);
        run_cmd(48, 48, 0, -1);
        run_cmd(48, 48, 50, -1);
        run_cmd(40, 20, 0, 2);
        #2 rst = 0;
        #1;
        chk("async_rst_outs", {cmd_ready, tile_valid, busy, first_k, last_k, last_tile}, 6'b100000);
        chk("async_rst_desc", {ksize, nsize, k_off, n_off}, 0);
        @(negedge clk);
        rst = 1; cmd_valid = 0; tile_ready = 0;
        @(negedge clk);
        run_cmd(40, 20, 30, -1);
        for (int i = 0; i < 8; i++)
            run_cmd($urandom_range(70, 1), $urandom_range(70, 1), 40, -1);
        run_cmd(65535, 1, 0, -1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
